// File: rtl/nic_pkg.sv
// Shared constants for the cpu_nic register map and default widths.
// Imported by nic_fifo and cpu_nic.
package nic_pkg;

  localparam int DATA_W_DEF     = 64;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // status flag lives in the LSB of the MSB-first data word
  localparam int STAT_BIT = DATA_W_DEF - 1;

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags, head and count.
// Push is ignored when full, pop is ignored when empty.
module nic_fifo
  import nic_pkg::*;
#(
  parameter int W     = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [0:W-1]             din,
  output logic                     full,
  output logic                     empty,
  output logic [0:W-1]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [0:W-1]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_nic.sv
// Memory-mapped NIC between the cmp data port and a ring router.
// Define NIC_COUNTERS_EN to add rx/tx/drop packet counters to the status regs.
module cpu_nic
  import nic_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr_in,
  input  logic              mem_en,
  input  logic              mem_wr_en,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              load;
  logic              store;
  logic              sel_in_buf;
  logic              sel_in_stat;
  logic              sel_out_buf;
  logic              sel_out_stat;
  logic              ready;
  logic              in_push;
  logic              in_pop;
  logic              in_full;
  logic              in_empty;
  logic [0:DATA_W-1] in_head;
  logic [CW-1:0]     in_count;
  logic              out_push;
  logic              out_pop;
  logic              out_full;
  logic              out_empty;
  logic [CW-1:0]     out_count;
  logic [0:DATA_W-1] in_stat;
  logic [0:DATA_W-1] out_stat;
  logic              unused_cnt;

  assign load         = mem_en & ~mem_wr_en;
  assign store        = mem_en & mem_wr_en;
  assign sel_in_buf   = addr_in == NIC_IN_BUF;
  assign sel_in_stat  = addr_in == NIC_IN_STAT;
  assign sel_out_buf  = addr_in == NIC_OUT_BUF;
  assign sel_out_stat = addr_in == NIC_OUT_STAT;
  assign unused_cnt   = ^{in_count, out_count};

  // holds net_ri low through reset and for the first edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ready <= 1'b0;
    else
      ready <= 1'b1;
  end

  assign net_ri   = ready & ~in_full;
  assign in_push  = net_si & net_ri;
  assign in_pop   = load & sel_in_buf & ~in_empty;
  assign out_push = store & sel_out_buf & ~out_full;
  assign net_so   = ~out_empty;
  assign out_pop  = net_so & net_ro;

  nic_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (in_push),
    .pop   (in_pop),
    .din   (net_di),
    .full  (in_full),
    .empty (in_empty),
    .head  (in_head),
    .count (in_count)
  );

  nic_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (d_in),
    .full  (out_full),
    .empty (out_empty),
    .head  (net_do),
    .count (out_count)
  );

`ifdef NIC_COUNTERS_EN
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop;

  assign drop = store & sel_out_buf & out_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (in_push && rx_cnt != '1)
        rx_cnt <= rx_cnt + 1'b1;
      if (out_pop && tx_cnt != '1)
        tx_cnt <= tx_cnt + 1'b1;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_comb begin
    in_stat                     = '0;
    in_stat[0:CNT_W-1]          = rx_cnt;
    in_stat[STAT_BIT]           = ~in_empty;
    out_stat                    = '0;
    out_stat[0:CNT_W-1]         = tx_cnt;
    out_stat[CNT_W:2*CNT_W-1]   = drop_cnt;
    out_stat[STAT_BIT]          = out_full;
  end
`else
  always_comb begin
    in_stat            = '0;
    in_stat[STAT_BIT]  = ~in_empty;
    out_stat           = '0;
    out_stat[STAT_BIT] = out_full;
  end
`endif

  always_comb begin
    d_out = '0;
    if (load) begin
      unique case (1'b1)
        sel_in_buf:   d_out = in_empty ? '0 : in_head;
        sel_in_stat:  d_out = in_stat;
        sel_out_stat: d_out = out_stat;
        sel_out_buf:  d_out = '0;
        default:      d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_nic.sv
// Scoreboard bench for cpu_nic: router sends and cmp loads are checked
// against queued expectations by a negedge monitor.
module tb_cpu_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:1]  addr_in = '0;
  logic        mem_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [0:63] d_in = '0;
  logic [0:63] d_out;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [0:63] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [0:63] net_di = '0;

  int total = 0;
  int bad = 0;
  logic [0:63] exp_net [$];
  logic [0:63] exp_ld [$];

  cpu_nic dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .mem_en    (mem_en),
    .mem_wr_en (mem_wr_en),
    .d_in      (d_in),
    .d_out     (d_out),
    .net_so    (net_so),
    .net_ro    (net_ro),
    .net_do    (net_do),
    .net_si    (net_si),
    .net_ri    (net_ri),
    .net_di    (net_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [0:63] act,
                     input logic [0:63] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [0:63] istat(input bit f, input int rx);
    logic [0:63] v;
    v = '0;
    v[63] = f;
`ifdef NIC_COUNTERS_EN
    v[0:15] = 16'(rx);
`endif
    return v;
  endfunction

  function automatic logic [0:63] ostat(input bit f, input int tx,
                                        input int dr);
    logic [0:63] v;
    v = '0;
    v[63] = f;
`ifdef NIC_COUNTERS_EN
    v[0:15]  = 16'(tx);
    v[16:31] = 16'(dr);
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (net_so && net_ro) begin
        if (exp_net.size() == 0) begin
          total++;
          bad++;
          $display("FAIL net_unexpected: got %h want none", net_do);
        end else begin
          chk("net_do", net_do, exp_net.pop_front());
        end
      end
      if (mem_en && !mem_wr_en) begin
        if (exp_ld.size() == 0) begin
          total++;
          bad++;
          $display("FAIL load_unexpected: got %h want none", d_out);
        end else begin
          chk("load_d_out", d_out, exp_ld.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [0:1] a, input logic [0:63] d);
    addr_in = a;
    d_in = d;
    mem_en = 1'b1;
    mem_wr_en = 1'b1;
    cyc();
    mem_en = 1'b0;
    mem_wr_en = 1'b0;
  endtask

  task automatic ld(input logic [0:1] a, input logic [0:63] e);
    exp_ld.push_back(e);
    addr_in = a;
    mem_en = 1'b1;
    mem_wr_en = 1'b0;
    cyc();
    mem_en = 1'b0;
  endtask

  task automatic rx(input logic [0:63] d);
    net_si = 1'b1;
    net_di = d;
    cyc();
    net_si = 1'b0;
  endtask

  localparam logic [0:63] PA = 64'h1111_0000_0000_0000;
  localparam logic [0:63] PB = 64'h2222_0000_0000_0000;
  localparam logic [0:63] PF = 64'h3333_0000_0000_0000;
  localparam logic [0:63] PH = 64'h4444_0000_0000_0000;

  initial begin
    int w;
    cyc(2);
    chk("rst_net_so", 64'(net_so), 64'd0);
    chk("rst_net_ri", 64'(net_ri), 64'd0);
    chk("rst_d_out", d_out, 64'd0);
    reset = 1'b1;
    cyc();
    chk("post_rst_net_ri", 64'(net_ri), 64'd1);
    chk("post_rst_net_so", 64'(net_so), 64'd0);

    net_ro = 1'b1;
    exp_net.push_back(64'hDEAD_BEEF_0000_0001);
    st(NIC_OUT_BUF_C(), 64'hDEAD_BEEF_0000_0001);
    chk("send_so", 64'(net_so), 64'd1);
    chk("send_do", net_do, 64'hDEAD_BEEF_0000_0001);
    cyc();
    chk("send_so_clr", 64'(net_so), 64'd0);
    net_ro = 1'b0;

    for (int i = 0; i < 4; i++) st(2'b10, PA | 64'(i));
    ld(2'b11, ostat(1, 1, 0));
    st(2'b10, 64'hBAD0_BAD0_BAD0_BAD0);
    ld(2'b11, ostat(1, 1, 1));
    for (int i = 0; i < 4; i++) exp_net.push_back(PA | 64'(i));
    net_ro = 1'b1;
    cyc(4);
    chk("drain_so", 64'(net_so), 64'd0);
    net_ro = 1'b0;
    ld(2'b11, ostat(0, 5, 1));
    ld(2'b10, 64'd0);

    for (int i = 0; i < 4; i++) rx(PB | 64'(i));
    chk("in_full_ri", 64'(net_ri), 64'd0);
    rx(64'hBAD1_BAD1_BAD1_BAD1);
    ld(2'b01, istat(1, 4));
    for (int i = 0; i < 4; i++) ld(2'b00, PB | 64'(i));
    ld(2'b01, istat(0, 4));
    chk("in_empty_ri", 64'(net_ri), 64'd1);

    ld(2'b00, 64'd0);
    ld(2'b01, istat(0, 4));
    st(2'b01, '1);
    st(2'b00, '1);
    st(2'b11, '1);
    ld(2'b01, istat(0, 4));
    ld(2'b11, ostat(0, 5, 1));
    rx(64'hC0C0_0000_0000_0000);
    net_si = 1'b1;
    net_di = 64'hC1C1_0000_0000_0000;
    exp_ld.push_back(64'hC0C0_0000_0000_0000);
    addr_in = 2'b00;
    mem_en = 1'b1;
    mem_wr_en = 1'b0;
    cyc();
    mem_en = 1'b0;
    net_si = 1'b0;
    ld(2'b01, istat(1, 6));
    ld(2'b00, 64'hC1C1_0000_0000_0000);
    ld(2'b01, istat(0, 6));

    rx(64'hD0);
    rx(64'hD1);
    st(2'b10, 64'hE0);
    st(2'b10, 64'hE1);
    chk("pre_rst_so", 64'(net_so), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_so", 64'(net_so), 64'd0);
    chk("mid_rst_ri", 64'(net_ri), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc();
    ld(2'b01, istat(0, 0));
    ld(2'b11, ostat(0, 0, 0));
    ld(2'b00, 64'd0);
    chk("after_rst_so", 64'(net_so), 64'd0);

    net_ro = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_net.push_back(PF | 64'(i));
      st(2'b10, PF | 64'(i));
    end
    cyc();
    net_ro = 1'b0;
    rx(64'h6060);
    rx(64'h6161);
    for (int i = 0; i < 4; i++) st(2'b10, PH | 64'(i));
    st(2'b10, 64'hBAD2);
    ld(2'b11, ostat(1, 3, 1));
    ld(2'b01, istat(1, 2));
    for (int i = 0; i < 4; i++) exp_net.push_back(PH | 64'(i));
    net_ro = 1'b1;
    cyc(4);
    net_ro = 1'b0;
    ld(2'b00, 64'h6060);
    ld(2'b00, 64'h6161);
    ld(2'b11, ostat(0, 7, 1));

    w = 0;
    while ((exp_net.size() != 0 || exp_ld.size() != 0) && w < 20) begin
      cyc();
      w++;
    end
    chk("queues_drained", 64'(exp_net.size() + exp_ld.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [0:1] NIC_OUT_BUF_C();
    return 2'b10;
  endfunction

endmodule
